// File: rtl/led_frame_arbiter.sv
// led_frame_arbiter: grants the double-buffered LED display to one of two
// frame producers for a whole frame, forwards the owner's pixel writes through
// one register stage, issues the page flip and waits for the display's
// acknowledgement before re-arbitrating round-robin.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// IDLE      | no owner; arbitrate pending requests (tie goes to the non-last)
// OWN       | owner's pixels forwarded; watchdog counts idle owner cycles
// FLIP_WAIT | flip issued; waiting for the display's flipped acknowledgement

module led_frame_arbiter #(
    parameter int unsigned WATCHDOG_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic [3:0]  x_0,
    input  logic [2:0]  y_0,
    input  logic        valid_0,
    input  logic [7:0]  red_0,
    input  logic [7:0]  green_0,
    input  logic [7:0]  blue_0,
    input  logic        flip_0,
    output logic        gnt_0,
    output logic        done_0,
    input  logic        req_1,
    input  logic [3:0]  x_1,
    input  logic [2:0]  y_1,
    input  logic        valid_1,
    input  logic [7:0]  red_1,
    input  logic [7:0]  green_1,
    input  logic [7:0]  blue_1,
    input  logic        flip_1,
    output logic        gnt_1,
    output logic        done_1,
    output logic        timeout,
    output logic [3:0]  x,
    output logic [2:0]  y,
    output logic        valid,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        flip,
    input  logic        flipped,
    output logic [15:0] frame_count
);

    localparam int unsigned WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN, FLIP_WAIT} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            gnt_0_q, gnt_0_d, gnt_1_q, gnt_1_d;
    logic            done_0_q, done_0_d, done_1_q, done_1_d;
    logic            timeout_q, timeout_d;
    logic            flip_q, flip_d;
    logic            valid_q, valid_d;
    logic [3:0]      x_q, x_d;
    logic [2:0]      y_q, y_d;
    logic [7:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    // Owner-selected client inputs; the other client is never looked at.
    logic       own_req, own_valid, own_flip;
    logic [3:0] own_x;
    logic [2:0] own_y;
    logic [7:0] own_red, own_green, own_blue;

    // Select the current owner's request, strobes and pixel data.
    always_comb begin
        own_req   = owner_q ? req_1   : req_0;
        own_valid = owner_q ? valid_1 : valid_0;
        own_flip  = owner_q ? flip_1  : flip_0;
        own_x     = owner_q ? x_1     : x_0;
        own_y     = owner_q ? y_1     : y_0;
        own_red   = owner_q ? red_1   : red_0;
        own_green = owner_q ? green_1 : green_0;
        own_blue  = owner_q ? blue_1  : blue_0;
    end

    // Next-state logic: arbitration, pixel forwarding, flip handshake, watchdog.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        gnt_0_d       = gnt_0_q;
        gnt_1_d       = gnt_1_q;
        done_0_d      = 1'b0;
        done_1_d      = 1'b0;
        timeout_d     = 1'b0;
        flip_d        = 1'b0;
        valid_d       = 1'b0;
        x_d           = x_q;
        y_d           = y_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        frame_count_d = frame_count_q;
        wdog_d        = wdog_q;

        case (state_q)
            IDLE: begin
                if (req_0 && (!req_1 || last_q)) begin
                    owner_d = 1'b0;
                    gnt_0_d = 1'b1;
                    wdog_d  = '0;
                    state_d = OWN;
                end else if (req_1) begin
                    owner_d = 1'b1;
                    gnt_1_d = 1'b1;
                    wdog_d  = '0;
                    state_d = OWN;
                end
            end

            OWN: begin
                valid_d = own_valid;
                x_d     = own_x;
                y_d     = own_y;
                red_d   = own_red;
                green_d = own_green;
                blue_d  = own_blue;
                if (own_flip) begin
                    // Flip beats a simultaneous abort or watchdog expiry.
                    flip_d  = 1'b1;
                    wdog_d  = '0;
                    state_d = FLIP_WAIT;
                end else if (!own_req || (!own_valid && wdog_q == WD_LAST)) begin
                    timeout_d = own_req;
                    gnt_0_d   = 1'b0;
                    gnt_1_d   = 1'b0;
                    last_d    = owner_q;
                    wdog_d    = '0;
                    state_d   = IDLE;
                end else if (own_valid) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end

            FLIP_WAIT: begin
                if (flipped) begin
                    done_0_d      = ~owner_q;
                    done_1_d      = owner_q;
                    gnt_0_d       = 1'b0;
                    gnt_1_d       = 1'b0;
                    last_d        = owner_q;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = IDLE;
                end
            end

            default: begin
                gnt_0_d = 1'b0;
                gnt_1_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the grant with no flip or done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            gnt_0_q       <= 1'b0;
            gnt_1_q       <= 1'b0;
            done_0_q      <= 1'b0;
            done_1_q      <= 1'b0;
            timeout_q     <= 1'b0;
            flip_q        <= 1'b0;
            valid_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            frame_count_q <= '0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            gnt_0_q       <= gnt_0_d;
            gnt_1_q       <= gnt_1_d;
            done_0_q      <= done_0_d;
            done_1_q      <= done_1_d;
            timeout_q     <= timeout_d;
            flip_q        <= flip_d;
            valid_q       <= valid_d;
            x_q           <= x_d;
            y_q           <= y_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            frame_count_q <= frame_count_d;
            wdog_q        <= wdog_d;
        end
    end

    assign gnt_0       = gnt_0_q;
    assign gnt_1       = gnt_1_q;
    assign done_0      = done_0_q;
    assign done_1      = done_1_q;
    assign timeout     = timeout_q;
    assign flip        = flip_q;
    assign valid       = valid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed bench for led_frame_arbiter with a 16-cycle watchdog.
// Inputs are driven 1 time unit after a rising edge and outputs are read at
// the same point, so a value driven after edge k is visible after edge k+1.

module tb_led_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_0, valid_0, flip_0, gnt_0, done_0;
    logic [3:0]  x_0;
    logic [2:0]  y_0;
    logic [7:0]  red_0, green_0, blue_0;
    logic        req_1, valid_1, flip_1, gnt_1, done_1;
    logic [3:0]  x_1;
    logic [2:0]  y_1;
    logic [7:0]  red_1, green_1, blue_1;
    logic        timeout, valid, flip, flipped;
    logic [3:0]  x;
    logic [2:0]  y;
    logic [7:0]  red, green, blue;
    logic [15:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0, flip_cnt = 0, done0_cnt = 0, done1_cnt = 0;

    led_frame_arbiter #(.WATCHDOG_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .x_0(x_0), .y_0(y_0), .valid_0(valid_0),
        .red_0(red_0), .green_0(green_0), .blue_0(blue_0), .flip_0(flip_0),
        .gnt_0(gnt_0), .done_0(done_0),
        .req_1(req_1), .x_1(x_1), .y_1(y_1), .valid_1(valid_1),
        .red_1(red_1), .green_1(green_1), .blue_1(blue_1), .flip_1(flip_1),
        .gnt_1(gnt_1), .done_1(done_1),
        .timeout(timeout), .x(x), .y(y), .valid(valid),
        .red(red), .green(green), .blue(blue), .flip(flip),
        .flipped(flipped), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (valid)  valid_cnt++;
        if (flip)   flip_cnt++;
        if (done_0) done0_cnt++;
        if (done_1) done1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int vc, fc, dc, n, want_c;

        rst = 1'b1;
        req_0 = 0; valid_0 = 0; flip_0 = 0; x_0 = 0; y_0 = 0; red_0 = 0; green_0 = 0; blue_0 = 0;
        req_1 = 0; valid_1 = 0; flip_1 = 0; x_1 = 0; y_1 = 0; red_1 = 0; green_1 = 0; blue_1 = 0;
        flipped = 0;
        tick; tick;
        rst = 1'b0;
        tick;

        // Reset state
        check("rst_ctl", 32'({gnt_0, gnt_1, done_0, done_1, timeout, flip, valid}), 32'd0);
        check("rst_pix", 32'({x, y, red, green, blue}), 32'd0);
        check("rst_cnt", 32'(frame_count), 32'd0);

        // Single client, with client 1 hammering its pixel and flip inputs
        valid_1 = 1; flip_1 = 1; x_1 = 4'hF; y_1 = 3'd7;
        red_1 = 8'hAA; green_1 = 8'hAA; blue_1 = 8'hAA;
        req_0 = 1;
        tick;
        check("single_gnt", 32'({gnt_1, gnt_0}), 32'd1);
        vc = valid_cnt; fc = flip_cnt;
        for (int yy = 0; yy < 8; yy++) begin
            for (int xx = 0; xx < 16; xx++) begin
                x_0 = xx[3:0]; y_0 = yy[2:0]; valid_0 = 1;
                red_0 = {1'b0, y_0, x_0}; green_0 = ~{1'b0, y_0, x_0}; blue_0 = {x_0, 1'b0, y_0};
                tick;
                check("pixel", {x, y, valid, red, green, blue},
                      {x_0, y_0, 1'b1, red_0, green_0, blue_0});
            end
        end
        valid_0 = 0; flip_0 = 1;
        tick;
        check("single_flip", 32'({flip, valid}), 32'd2);
        flip_0 = 0;
        tick;
        check("single_flip_len", 32'({flip, gnt_0}), 32'd1);
        repeat (4) tick;
        flipped = 1;
        tick;
        check("single_done", 32'({done_0, gnt_0, gnt_1}), 32'd4);
        check("single_count", 32'(frame_count), 32'd1);
        flipped = 0; req_0 = 0;
        tick;
        check("single_done_len", 32'({done_0, gnt_1}), 32'd0);
        check("single_nvalid", 32'(valid_cnt - vc), 32'd128);
        check("isolate_flips", 32'(flip_cnt - fc), 32'd1);
        valid_1 = 0; flip_1 = 0;

        // Tie after reset: strict alternation starting with client 0
        rst = 1; tick; rst = 0; tick;
        req_0 = 1; req_1 = 1;
        tick;
        for (int i = 0; i < 4; i++) begin
            want_c = i % 2;
            check("tie_gnt", 32'({gnt_1, gnt_0}), (want_c != 0) ? 32'd2 : 32'd1);
            if (want_c != 0) flip_1 = 1; else flip_0 = 1;
            tick;
            check("tie_flip", 32'(flip), 32'd1);
            flip_0 = 0; flip_1 = 0;
            tick;
            flipped = 1;
            tick;
            check("tie_done", 32'({done_1, done_0, gnt_1, gnt_0}), (want_c != 0) ? 32'h8 : 32'h4);
            check("tie_count", 32'(frame_count), 32'(i + 1));
            flipped = 0;
            if (i == 3) begin req_0 = 0; req_1 = 0; end
            tick;
        end

        // Abort: client 0 writes 3 pixels then drops req; client 1 pending
        req_0 = 1; req_1 = 1;
        tick;
        check("abort_gnt", 32'({gnt_1, gnt_0}), 32'd1);
        for (int i = 0; i < 3; i++) begin
            x_0 = 4'(i + 3); y_0 = 3'(i); valid_0 = 1; red_0 = 8'(8'h10 + i);
            tick;
            check("abort_pix", 32'({valid, x, red}), 32'({1'b1, x_0, red_0}));
        end
        fc = flip_cnt; dc = done0_cnt;
        valid_0 = 0; req_0 = 0;
        tick;
        check("abort_drop", 32'({gnt_1, gnt_0, flip, done_0}), 32'd0);
        tick;
        check("abort_next", 32'({gnt_1, gnt_0}), 32'd2);
        check("abort_noflip", 32'(flip_cnt - fc), 32'd0);
        check("abort_nodone", 32'(done0_cnt - dc), 32'd0);
        check("abort_count", 32'(frame_count), 32'd4);

        // Watchdog: client 1 idle from grant
        n = 0;
        do begin
            tick;
            n++;
        end while (gnt_1 && n < 40);
        check("wd_cycles", 32'(n), 32'd16);
        check("wd_timeout", 32'(timeout), 32'd1);
        tick;
        check("wd_pulse_regnt", 32'({timeout, gnt_1}), 32'd1);

        // Watchdog restart: one valid_1 sampled 10 edges after the regrant
        repeat (9) tick;
        x_1 = 4'h9; y_1 = 3'd5; red_1 = 8'h5A; green_1 = 8'hC3; blue_1 = 8'h3C; valid_1 = 1;
        tick;
        check("wd_valid", 32'({valid, x, y, red}), 32'({1'b1, 4'h9, 3'd5, 8'h5A}));
        valid_1 = 0;
        n = 10;
        do begin
            tick;
            n++;
        end while (gnt_1 && n < 60);
        check("wd_restart", 32'(n), 32'd26);
        check("wd_timeout2", 32'(timeout), 32'd1);
        req_1 = 0;
        tick;
        check("wd_release", 32'({timeout, gnt_1}), 32'd0);

        // Asynchronous reset while waiting for the flip acknowledgement
        req_0 = 1;
        tick;
        check("rstfw_gnt", 32'(gnt_0), 32'd1);
        flip_0 = 1;
        tick;
        flip_0 = 0;
        check("rstfw_flip", 32'(flip), 32'd1);
        tick;
        check("rstfw_wait", 32'({flip, gnt_0}), 32'd1);
        #2 rst = 1;
        #1;
        check("rstfw_ctl", 32'({gnt_0, gnt_1, done_0, done_1, timeout, flip, valid}), 32'd0);
        check("rstfw_pix", 32'({x, y, red, green, blue}), 32'd0);
        check("rstfw_cnt", 32'(frame_count), 32'd0);
        req_0 = 0;
        @(negedge clk);
        rst = 0;
        tick;
        dc = done0_cnt;
        flipped = 1;
        tick;
        flipped = 0;
        check("rstfw_nodone", 32'({done_0, done_1, gnt_0, gnt_1}), 32'd0);
        req_0 = 1; req_1 = 1;
        tick;
        check("rstfw_tie", 32'({gnt_1, gnt_0}), 32'd1);
        check("rstfw_nodone_cnt", 32'(done0_cnt - dc), 32'd0);
        req_0 = 0; req_1 = 0;
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
